command_fsm: RTL and testbench
==============================

COMMAND_FSM -- requirements
Module: command_fsm

Interface
REQ-001 Parameter T_SETUP, default 2, clock cycles of RS/data setup before LCD_E rises (40 ns at 50 MHz).
REQ-002 Parameter T_EN, default 12, clock cycles LCD_E is held high per nibble (240 ns).
REQ-003 Parameter T_HOLD, default 1, clock cycles of data hold after LCD_E falls.
REQ-004 Parameter T_GAP, default 50, clock cycles between the upper-nibble and lower-nibble transfers (1 us).
REQ-005 Parameter T_WAIT_SHORT, default 2000, post-command wait in clock cycles (40 us).
REQ-006 Parameter T_WAIT_MID, default 5000, post-command wait in clock cycles (100 us).
REQ-007 Parameter T_WAIT_LONG, default 82000, post-command wait in clock cycles (1.64 ms).
REQ-008 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-009 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-010 Port ready, input, 1 bit: command request, level-sensitive.
REQ-011 Port DB, input, 8 bits: command/data byte to transfer.
REQ-012 Port instruction, input, 4 bits: [3] is the RS value, [2] is reserved and ignored, [1:0] selects the post-command wait.
REQ-013 Port SF_D, output, 4 bits: LCD data nibble (SF_D[11:8] of the board).
REQ-014 Port LCD_E, output, 1 bit: LCD enable strobe.
REQ-015 Port LCD_RS, output, 1 bit: register select (0 = command, 1 = data).
REQ-016 Port LCD_RW, output, 1 bit: read/write select; the block is write-only and drives it constantly 0.

Function
REQ-017 The state machine SHALL have these states: IDLE, UP_SETUP, UP_EN, UP_HOLD, GAP, LO_SETUP, LO_EN, LO_HOLD, WAIT.
REQ-018 In IDLE, when ready=1 at a clock edge, the block SHALL latch DB and instruction and enter UP_SETUP on that edge.
REQ-019 Latched values SHALL be used for the whole command; changes on DB, instruction or ready after the latch edge SHALL be ignored until IDLE is re-entered.
REQ-020 Upper-nibble transfer: SF_D=DB[7:4] and LCD_RS=instruction[3] from UP_SETUP through UP_HOLD.
REQ-021 The state SHALL be UP_SETUP for T_SETUP cycles, then UP_EN for T_EN cycles, then UP_HOLD for T_HOLD cycles.
REQ-022 LCD_E SHALL be 1 only in UP_EN and LO_EN, and it SHALL be driven from a register (glitch-free).
REQ-023 After UP_HOLD, the block SHALL spend T_GAP cycles in GAP with LCD_E=0.
REQ-024 The lower nibble (LO_SETUP, LO_EN, LO_HOLD) SHALL repeat the upper-nibble sequence with SF_D=DB[3:0].
REQ-025 WAIT duration by latched instruction[1:0]: 00 = T_WAIT_SHORT, 01 = T_WAIT_MID, 10 = T_WAIT_LONG, 11 = T_WAIT_SHORT.
REQ-026 At the end of WAIT the block SHALL return to IDLE.
REQ-027 If ready is still 1 on the first IDLE cycle, the next command SHALL start on that edge.
REQ-028 Outside a transfer (IDLE, GAP, WAIT), SF_D SHALL hold its last value and LCD_E SHALL be 0.
REQ-029 A single down-counter SHALL time every state, sized to hold T_WAIT_LONG; it is reloaded on each state entry.
REQ-030 An X or 0 on ready in IDLE SHALL NOT start a command.

Reset
REQ-031 While reset=0 the block SHALL asynchronously set: state=IDLE, counter=0, SF_D=0, LCD_E=0, LCD_RS=0, LCD_RW=0, latched DB and instruction = 0.
REQ-032 Reset asserted mid-command SHALL abort the command immediately with LCD_E=0; there is no resumption.
REQ-033 The first command may be accepted on the first clock edge after reset rises.

Configuration
REQ-034 The macro CMD_FSM_LONG_WAIT_EN controls the long wait.
REQ-035 With CMD_FSM_LONG_WAIT_EN defined, instruction[1:0]=10 SHALL select T_WAIT_LONG.
REQ-036 Without CMD_FSM_LONG_WAIT_EN, 10 SHALL select T_WAIT_SHORT, and the counter SHALL be sized for T_WAIT_MID only.

Structure
REQ-037 A shared package lcd_cmd_pkg SHALL hold the state enumeration, the default timing constants and the wait-select encodings.
REQ-038 One sub-module, cmd_delay_counter, SHALL provide loadable down-counting with a terminal-count flag; all other logic stays in command_fsm.

Verification
REQ-039 Reset held low 200 ns then released -> all outputs 0 and the state is IDLE.
REQ-040 DB=0x28, instruction=1011, ready=1 for 400 ns ->
- SF_D=0x2, LCD_RS=1, LCD_E high for exactly 12 cycles;
- 50-cycle gap;
- SF_D=0x8, LCD_E high for 12 cycles;
- 2000-cycle wait, then IDLE, with no second command.
REQ-041 ready raised again 50 us after the first request -> a second identical command starts on the next edge in IDLE.
REQ-042 instruction=0010, DB=0x01 -> LCD_RS=0 throughout, and the wait is 82000 cycles with the macro defined and 2000 without.
REQ-043 DB changed to 0xFF during GAP -> the lower nibble is still 0x8.
REQ-044 Reset driven low during UP_EN -> LCD_E falls immediately and the state is IDLE; LCD_RW stays 0 in all scenarios.

Source files
------------

// File: rtl/lcd_cmd_pkg.sv
// Shared LCD command definitions: FSM states, default timing and wait-select codes.
// Long-wait support is enabled in command_fsm via CMD_FSM_LONG_WAIT_EN.
package lcd_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    UP_SETUP,
    UP_EN,
    UP_HOLD,
    GAP,
    LO_SETUP,
    LO_EN,
    LO_HOLD,
    WAIT
  } cmd_state_e;

  // Default timings in clock cycles at 50 MHz
  localparam int unsigned DEF_T_SETUP      = 2;
  localparam int unsigned DEF_T_EN         = 12;
  localparam int unsigned DEF_T_HOLD       = 1;
  localparam int unsigned DEF_T_GAP        = 50;
  localparam int unsigned DEF_T_WAIT_SHORT = 2000;
  localparam int unsigned DEF_T_WAIT_MID   = 5000;
  localparam int unsigned DEF_T_WAIT_LONG  = 82000;

  localparam logic [1:0] WSEL_SHORT     = 2'b00;
  localparam logic [1:0] WSEL_MID       = 2'b01;
  localparam logic [1:0] WSEL_LONG      = 2'b10;
  localparam logic [1:0] WSEL_SHORT_ALT = 2'b11;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cmd_delay_counter.sv
// Loadable down-counter that stops at zero; tc_o flags the terminal count.
module cmd_delay_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/command_fsm.sv
// Writes one byte to a 4-bit HD44780-style LCD as two timed nibbles, then waits.
// Define CMD_FSM_LONG_WAIT_EN to make wait select 2'b10 use T_WAIT_LONG.
module command_fsm
  import lcd_cmd_pkg::*;
#(
  parameter int unsigned T_SETUP      = DEF_T_SETUP,
  parameter int unsigned T_EN         = DEF_T_EN,
  parameter int unsigned T_HOLD       = DEF_T_HOLD,
  parameter int unsigned T_GAP        = DEF_T_GAP,
  parameter int unsigned T_WAIT_SHORT = DEF_T_WAIT_SHORT,
  parameter int unsigned T_WAIT_MID   = DEF_T_WAIT_MID,
  parameter int unsigned T_WAIT_LONG  = DEF_T_WAIT_LONG
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready,
  input  logic [7:0] DB,
  input  logic [3:0] instruction,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  localparam int unsigned BASE_MAX = max_u(max_u(max_u(T_SETUP, T_EN), max_u(T_HOLD, T_GAP)),
                                           max_u(T_WAIT_SHORT, T_WAIT_MID));
`ifdef CMD_FSM_LONG_WAIT_EN
  localparam int unsigned CNT_MAX = max_u(BASE_MAX, T_WAIT_LONG);
`else
  localparam int unsigned CNT_MAX = BASE_MAX;
  localparam int unsigned UNUSED_T_WAIT_LONG = T_WAIT_LONG;
`endif
  localparam int unsigned CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  // A state lasting n cycles is entered with the counter loaded to n-1
  function automatic logic [CNT_W-1:0] ld(input int unsigned n);
    return (n == 0) ? '0 : CNT_W'(n - 1);
  endfunction

  cmd_state_e       state_q, state_d;
  logic [7:0]       db_q, db_d;
  logic             rs_sel_q, rs_sel_d;
  logic [1:0]       wsel_q, wsel_d;
  logic [3:0]       sf_q, sf_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] wait_ld;
  logic             tc;
  logic             unused_instr_bit;

  assign unused_instr_bit = instruction[2];

  cmd_delay_counter #(.W(CNT_W)) u_delay (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .tc_o       (tc)
  );

  always_comb begin
    wait_ld = ld(T_WAIT_SHORT);
    case (wsel_q)
      WSEL_MID:       wait_ld = ld(T_WAIT_MID);
`ifdef CMD_FSM_LONG_WAIT_EN
      WSEL_LONG:      wait_ld = ld(T_WAIT_LONG);
`else
      WSEL_LONG:      wait_ld = ld(T_WAIT_SHORT);
`endif
      WSEL_SHORT,
      WSEL_SHORT_ALT: wait_ld = ld(T_WAIT_SHORT);
      default:        wait_ld = ld(T_WAIT_SHORT);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    db_d     = db_q;
    rs_sel_d = rs_sel_q;
    wsel_d   = wsel_q;
    sf_d     = sf_q;
    rs_d     = rs_q;
    unique case (state_q)
      IDLE: begin
        if (ready) begin
          db_d     = DB;
          rs_sel_d = instruction[3];
          wsel_d   = instruction[1:0];
          sf_d     = DB[7:4];
          rs_d     = instruction[3];
          state_d  = UP_SETUP;
        end
      end
      UP_SETUP, UP_EN, UP_HOLD: begin
        sf_d = db_q[7:4];
        rs_d = rs_sel_q;
        if (tc) begin
          case (state_q)
            UP_SETUP: state_d = UP_EN;
            UP_EN:    state_d = UP_HOLD;
            default:  state_d = GAP;
          endcase
        end
      end
      GAP: begin
        if (tc) begin
          sf_d    = db_q[3:0];
          state_d = LO_SETUP;
        end
      end
      LO_SETUP, LO_EN, LO_HOLD: begin
        sf_d = db_q[3:0];
        rs_d = rs_sel_q;
        if (tc) begin
          case (state_q)
            LO_SETUP: state_d = LO_EN;
            LO_EN:    state_d = LO_HOLD;
            default:  state_d = WAIT;
          endcase
        end
      end
      WAIT: begin
        if (tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobe follows the next state so it is registered alongside it
    e_d      = (state_d == UP_EN) || (state_d == LO_EN);
    cnt_load = (state_d != state_q);
    unique case (state_d)
      UP_SETUP, LO_SETUP: cnt_val = ld(T_SETUP);
      UP_EN, LO_EN:       cnt_val = ld(T_EN);
      UP_HOLD, LO_HOLD:   cnt_val = ld(T_HOLD);
      GAP:                cnt_val = ld(T_GAP);
      WAIT:               cnt_val = wait_ld;
      default:            cnt_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      db_q     <= '0;
      rs_sel_q <= 1'b0;
      wsel_q   <= '0;
      sf_q     <= '0;
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_q     <= db_d;
      rs_sel_q <= rs_sel_d;
      wsel_q   <= wsel_d;
      sf_q     <= sf_d;
      e_q      <= e_d;
      rs_q     <= rs_d;
    end
  end

  assign SF_D   = sf_q;
  assign LCD_E  = e_q;
  assign LCD_RS = rs_q;
  assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_command_fsm.sv
// Directed bench for command_fsm at default timing; honours CMD_FSM_LONG_WAIT_EN.
`timescale 1ns/1ps
module tb_command_fsm;
  import lcd_cmd_pkg::*;

`ifdef CMD_FSM_LONG_WAIT_EN
  localparam int EXP_SEL10_WAIT = 82000;
`else
  localparam int EXP_SEL10_WAIT = 2000;
`endif
  localparam int LIMIT = 100000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] DB = 8'h00;
  logic [3:0] instruction = 4'h0;
  logic [3:0] SF_D;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n;
  int c0;

  command_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .ready       (ready),
    .DB          (DB),
    .instruction (instruction),
    .SF_D        (SF_D),
    .LCD_E       (LCD_E),
    .LCD_RS      (LCD_RS),
    .LCD_RW      (LCD_RW)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n = negedges with LCD_E != v before the one where LCD_E == v; -1 on timeout
  task automatic wait_e(input logic v, output int cnt);
    cnt = -1;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (LCD_E === v) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic wait_state(input cmd_state_e s, output int cnt);
    cnt = -1;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (dut.state_q === s) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    // Reset held 200 ns, released on a falling edge
    #200 reset = 1'b1;
    #1;
    chk("rst_sfd", 32'(SF_D), 32'h0);
    chk("rst_e", 32'(LCD_E), 32'h0);
    chk("rst_rs", 32'(LCD_RS), 32'h0);
    chk("rst_rw", 32'(LCD_RW), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));

    // Command 1: DB=0x28, instruction=1011, ready high for 400 ns
    @(negedge clk);
    c0 = cyc;
    DB = 8'h28; instruction = 4'b1011; ready = 1'b1;
    fork
      #400 ready = 1'b0;
    join_none
    @(posedge clk); #1;
    chk("c1_state", 32'(dut.state_q), 32'(UP_SETUP));
    chk("c1_sfd_up", 32'(SF_D), 32'h2);
    chk("c1_rs", 32'(LCD_RS), 32'h1);
    chk("c1_e_setup", 32'(LCD_E), 32'h0);
    wait_e(1'b1, n);
    chk("c1_setup_len", 32'(n), 32'd2);
    chk("c1_sfd_en_up", 32'(SF_D), 32'h2);
    wait_e(1'b0, n);
    chk("c1_up_high", 32'(n + 1), 32'd12);
    wait_e(1'b1, n);
    chk("c1_low_between", 32'(n + 1), 32'd53);
    chk("c1_sfd_en_lo", 32'(SF_D), 32'h8);
    chk("c1_rs_lo", 32'(LCD_RS), 32'h1);
    wait_e(1'b0, n);
    chk("c1_lo_high", 32'(n + 1), 32'd12);
    wait_state(IDLE, n);
    chk("c1_wait_len", 32'(n), 32'd2000);
    repeat (20) @(negedge clk);
    chk("c1_no_second", 32'(dut.state_q), 32'(IDLE));
    chk("c1_idle_sfd_hold", 32'(SF_D), 32'h8);
    chk("c1_idle_e", 32'(LCD_E), 32'h0);

    // Command 2: ready raised 50 us after the first request
    while (cyc - c0 < 2500) @(negedge clk);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    chk("c2_state", 32'(dut.state_q), 32'(UP_SETUP));
    chk("c2_sfd_up", 32'(SF_D), 32'h2);
    wait_state(IDLE, n);
    chk("c2_total_len", 32'(n), 32'd2080);

    // Command 3: RS=0, wait select 10
    @(negedge clk);
    DB = 8'h01; instruction = 4'b0010; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    chk("c3_rs_setup", 32'(LCD_RS), 32'h0);
    chk("c3_sfd_up", 32'(SF_D), 32'h0);
    wait_e(1'b1, n);
    wait_e(1'b0, n);
    wait_e(1'b1, n);
    chk("c3_sfd_lo", 32'(SF_D), 32'h1);
    chk("c3_rs_lo", 32'(LCD_RS), 32'h0);
    wait_e(1'b0, n);
    wait_state(IDLE, n);
    chk("c3_wait_len", 32'(n), 32'(EXP_SEL10_WAIT));
    chk("c3_rs_idle", 32'(LCD_RS), 32'h0);

    // Command 4: inputs changed during GAP must not affect the command
    @(negedge clk);
    DB = 8'h28; instruction = 4'b1011; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    wait_state(GAP, n);
    DB = 8'hFF; instruction = 4'b0001;
    wait_e(1'b1, n);
    chk("c4_sfd_lo", 32'(SF_D), 32'h8);
    chk("c4_rs_lo", 32'(LCD_RS), 32'h1);
    wait_e(1'b0, n);
    wait_state(IDLE, n);
    chk("c4_wait_len", 32'(n), 32'd2000);

    // Command 5: reset during UP_EN aborts at once
    @(negedge clk);
    DB = 8'h28; instruction = 4'b1011; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    wait_e(1'b1, n);
    #2 reset = 1'b0;
    #1;
    chk("c5_abort_e", 32'(LCD_E), 32'h0);
    chk("c5_abort_state", 32'(dut.state_q), 32'(IDLE));
    chk("c5_abort_sfd", 32'(SF_D), 32'h0);
    chk("c5_abort_rw", 32'(LCD_RW), 32'h0);

    // First edge after reset release accepts a command
    @(negedge clk);
    ready = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    chk("c6_first_edge", 32'(dut.state_q), 32'(UP_SETUP));
    chk("c6_rw", 32'(LCD_RW), 32'h0);
    wait_state(IDLE, n);
    chk("c6_total_len", 32'(n), 32'd2080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
